// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Optional alignment checking is enabled by defining FETCH_ALIGN_CHECK_EN.
package fetch_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2
  } fetch_state_t;

  function automatic int addr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: jump beats branch beats sequential fetch_pc + 4.
// Redirect targets are always word-aligned here; misalignment is reported by the top.
module pc_next_sel (
  input  logic [31:0] i_fetch_pc,
  input  logic        i_jump,
  input  logic [31:0] i_jump_target,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  output logic [31:0] o_next_pc,
  output logic        o_redirect
);

  logic [31:0] w_jump_aligned;
  logic [31:0] w_branch_aligned;

  assign w_jump_aligned   = i_jump_target   & 32'hFFFF_FFFC;
  assign w_branch_aligned = i_branch_target & 32'hFFFF_FFFC;

  always_comb begin
    o_next_pc  = i_fetch_pc + 32'd4;
    o_redirect = 1'b0;
    if (i_jump) begin
      o_next_pc  = w_jump_aligned;
      o_redirect = 1'b1;
    end else if (i_branch_taken) begin
      o_next_pc  = w_branch_aligned;
      o_redirect = 1'b1;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, fetch FSM and response pairing in front of a 1-cycle registered imem.
// Define FETCH_ALIGN_CHECK_EN to get a sticky align_err on misaligned redirect targets.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter int          INST_DEPTH = 256,
  parameter int          ADDR_W     = addr_w(INST_DEPTH),
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              resetpc,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  input  logic              jump,
  input  logic [31:0]       jump_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_inst,
  output logic [31:0]       inst_out,
  output logic [31:0]       pc_out,
  output logic [31:0]       pc_plus4_out,
  output logic              inst_valid,
  output logic              align_err
);

  logic [31:0]  r_fetch_pc;
  logic [31:0]  r_resp_pc;
  logic         r_resp_valid;
  fetch_state_t r_state;

  logic [31:0]  w_fetch_pc_next;
  logic [31:0]  w_resp_pc_next;
  logic         w_resp_valid_next;
  fetch_state_t w_state_next;
  logic [31:0]  w_next_pc;
  logic         w_redirect;
  logic         w_replay;
  logic [31:0]  w_resp_pc_vis;

  pc_next_sel u_next_sel (
    .i_fetch_pc      (r_fetch_pc),
    .i_jump          (jump),
    .i_jump_target   (jump_target),
    .i_branch_taken  (branch_taken),
    .i_branch_target (branch_target),
    .o_next_pc       (w_next_pc),
    .o_redirect      (w_redirect)
  );

  // Re-presenting resp_pc while stalled keeps imem_inst stable for decode.
  assign w_replay  = stall && (r_state != S_BOOT);
  assign imem_addr = w_replay ? r_resp_pc[ADDR_W+1:2] : r_fetch_pc[ADDR_W+1:2];

  always_comb begin
    w_fetch_pc_next   = r_fetch_pc;
    w_resp_pc_next    = r_resp_pc;
    w_resp_valid_next = r_resp_valid;
    w_state_next      = r_state;
    case (r_state)
      S_BOOT: begin
        w_resp_pc_next    = r_fetch_pc;
        w_resp_valid_next = 1'b1;
        w_fetch_pc_next   = r_fetch_pc + 32'd4;
        w_state_next      = S_RUN;
      end
      default: begin
        if (w_redirect) begin
          w_fetch_pc_next   = w_next_pc;
          w_resp_valid_next = 1'b0;
          w_state_next      = S_RUN;
        end else if (stall) begin
          w_state_next      = S_STALL;
        end else begin
          w_resp_pc_next    = r_fetch_pc;
          w_resp_valid_next = 1'b1;
          w_fetch_pc_next   = w_next_pc;
          w_state_next      = S_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetpc) begin
      r_fetch_pc   <= RESET_PC;
      r_resp_pc    <= RESET_PC;
      r_resp_valid <= 1'b0;
      r_state      <= S_BOOT;
    end else begin
      r_fetch_pc   <= w_fetch_pc_next;
      r_resp_pc    <= w_resp_pc_next;
      r_resp_valid <= w_resp_valid_next;
      r_state      <= w_state_next;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_align_err;
  logic w_misaligned;

  assign w_misaligned = jump ? (|jump_target[1:0])
                             : (branch_taken && (|branch_target[1:0]));

  always_ff @(posedge clk) begin
    if (resetpc)
      r_align_err <= 1'b0;
    else if (r_state != S_BOOT && w_misaligned)
      r_align_err <= 1'b1;
  end

  assign align_err = r_align_err;
`else
  assign align_err = 1'b0;
`endif

  // Outputs are forced to their reset values while resetpc is high, even before the first edge.
  assign w_resp_pc_vis = resetpc ? RESET_PC : r_resp_pc;
  assign inst_valid    = r_resp_valid && !resetpc;
  assign inst_out      = inst_valid ? imem_inst : NOP_INST;
  assign pc_out        = w_resp_pc_vis;
  assign pc_plus4_out  = w_resp_pc_vis + 32'd4;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a registered 256-word memory holding 0x1000_0000+k.
// Expected align_err depends on FETCH_ALIGN_CHECK_EN.
module tb_pc_fetch_unit;

  logic        clk;
  logic        resetpc;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [7:0]  imem_addr;
  logic [31:0] imem_inst;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4_out;
  logic        inst_valid;
  logic        align_err;

  logic [31:0] mem [256];
  int          n_checks;
  int          n_fail;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam logic [31:0] EXP_ALIGN = 32'd1;
`else
  localparam logic [31:0] EXP_ALIGN = 32'd0;
`endif

  pc_fetch_unit #(
    .INST_DEPTH (256),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .resetpc       (resetpc),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem_addr     (imem_addr),
    .imem_inst     (imem_inst),
    .inst_out      (inst_out),
    .pc_out        (pc_out),
    .pc_plus4_out  (pc_plus4_out),
    .inst_valid    (inst_valid),
    .align_err     (align_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) imem_inst <= mem[imem_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_inst(input string tag, input logic [31:0] pc, input logic [31:0] inst);
    check_eq({tag, ".valid"}, {31'd0, inst_valid}, 32'd1);
    check_eq({tag, ".pc"}, pc_out, pc);
    check_eq({tag, ".inst"}, inst_out, inst);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int k = 0; k < 256; k++) mem[k] = 32'h1000_0000 + k;
    resetpc = 1'b1; stall = 1'b0;
    branch_taken = 1'b0; branch_target = 32'h0;
    jump = 1'b0; jump_target = 32'h0;
    tick();
    tick();

    // reset state
    check_eq("rst.valid", {31'd0, inst_valid}, 32'd0);
    check_eq("rst.pc", pc_out, 32'h0);
    check_eq("rst.pc4", pc_plus4_out, 32'h4);
    check_eq("rst.inst", inst_out, 32'h0);
    check_eq("rst.align", {31'd0, align_err}, 32'd0);

    // boot cycle then back-to-back stream
    resetpc = 1'b0;
    #1;
    check_eq("boot.valid", {31'd0, inst_valid}, 32'd0);
    check_eq("boot.addr", {24'd0, imem_addr}, 32'd0);
    tick();
    expect_inst("seq0", 32'h0, 32'h1000_0000);
    check_eq("seq0.pc4", pc_plus4_out, 32'h4);
    tick();
    expect_inst("seq1", 32'h4, 32'h1000_0001);
    tick();
    expect_inst("seq2", 32'h8, 32'h1000_0002);

    // stall for three cycles at pc 8
    stall = 1'b1;
    #1;
    check_eq("stall.addr", {24'd0, imem_addr}, 32'd2);
    tick();
    expect_inst("stall2", 32'h8, 32'h1000_0002);
    tick();
    expect_inst("stall3", 32'h8, 32'h1000_0002);
    stall = 1'b0;
    #1;
    check_eq("unstall.addr", {24'd0, imem_addr}, 32'd3);
    check_eq("unstall.pc", pc_out, 32'h8);
    tick();
    expect_inst("after_stall", 32'hC, 32'h1000_0003);

    // taken branch to 0x40
    branch_taken = 1'b1; branch_target = 32'h40;
    tick();
    branch_taken = 1'b0;
    check_eq("br.squash", {31'd0, inst_valid}, 32'd0);
    tick();
    expect_inst("br.tgt", 32'h40, 32'h1000_0010);
    tick();
    expect_inst("br.next", 32'h44, 32'h1000_0011);

    // jump and branch together under stall: jump wins
    stall = 1'b1; jump = 1'b1; jump_target = 32'h80;
    branch_taken = 1'b1; branch_target = 32'h40;
    tick();
    stall = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    check_eq("jb.squash", {31'd0, inst_valid}, 32'd0);
    tick();
    expect_inst("jb.tgt", 32'h80, 32'h1000_0020);

    // address wrap at end of memory
    jump = 1'b1; jump_target = 32'h3F8;
    tick();
    jump = 1'b0;
    check_eq("wrap.squash", {31'd0, inst_valid}, 32'd0);
    tick();
    expect_inst("wrap.3f8", 32'h3F8, 32'h1000_00FE);
    check_eq("wrap.addr255", {24'd0, imem_addr}, 32'd255);
    tick();
    expect_inst("wrap.3fc", 32'h3FC, 32'h1000_00FF);
    check_eq("wrap.addr0", {24'd0, imem_addr}, 32'd0);
    tick();
    expect_inst("wrap.400", 32'h400, 32'h1000_0000);
    check_eq("wrap.pc4", pc_plus4_out, 32'h404);

    // reset asserted mid-stall
    stall = 1'b1;
    tick();
    expect_inst("rs.stall", 32'h400, 32'h1000_0000);
    resetpc = 1'b1;
    #1;
    check_eq("rs.valid_hi", {31'd0, inst_valid}, 32'd0);
    check_eq("rs.pc_hi", pc_out, 32'h0);
    tick();
    resetpc = 1'b0; stall = 1'b0;
    #1;
    check_eq("rs.boot_valid", {31'd0, inst_valid}, 32'd0);
    tick();
    expect_inst("rs.first", 32'h0, 32'h1000_0000);

    // misaligned jump target
    jump = 1'b1; jump_target = 32'h42;
    tick();
    jump = 1'b0;
    check_eq("mis.squash", {31'd0, inst_valid}, 32'd0);
    check_eq("mis.align1", {31'd0, align_err}, EXP_ALIGN);
    tick();
    expect_inst("mis.tgt", 32'h40, 32'h1000_0010);
    check_eq("mis.align2", {31'd0, align_err}, EXP_ALIGN);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
